// File: rtl/alu_pkg.sv
// Shared definitions for the registered 16-bit ALU: datapath width and opcode encoding.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int RES_W  = 2 * DATA_W;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_MUL   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_HALVE = 3'b100,
        OP_GT    = 3'b101,
        OP_LT    = 3'b110,
        OP_SLL   = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result, zero detect and unsigned magnitude compares.
module alu_core
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  alu_op_e           op_i,
    output logic [RES_W-1:0]  r_o,
    output logic              zero_o,
    output logic              gt_o,
    output logic              lt_o
);

    logic [DATA_W-1:0] sum;

    assign sum = a_i + b_i;

    // NOTE: r_o is assigned before the case so every path drives it and no latch is inferred.
    always_comb begin
        r_o = '0;
        case (op_i)
            OP_ADD:   r_o = {{DATA_W{sum[DATA_W-1]}}, sum};
            OP_MUL:   r_o = RES_W'(a_i) * RES_W'(b_i);
            OP_AND:   r_o = RES_W'(a_i & b_i);
            OP_OR:    r_o = RES_W'(a_i | b_i);
            OP_HALVE: r_o = RES_W'(a_i >> 1);
            OP_GT:    r_o = RES_W'(a_i > b_i);
            OP_LT:    r_o = RES_W'(a_i < b_i);
            OP_SLL:   r_o = RES_W'(a_i) << b_i[3:0];
            default:  r_o = '0;
        endcase
    end

    assign zero_o = (r_o == '0);
    assign gt_o   = (a_i > b_i);
    assign lt_o   = (a_i < b_i);

endmodule

// File: rtl/alu_main.sv
// Registered ALU: one operation accepted per cycle, all outputs valid one clock later.
module alu_main
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   d_in_1,
    input  logic [DATA_W-1:0]   d_in_2,
    input  logic [2:0]          alu_op,
    output logic [RES_W-1:0]    d_out,
    output logic                z_flag,
    output logic                a_grt_b,
    output logic                b_grt_a
);

    logic [RES_W-1:0] d_out_d, d_out_q;
    logic             z_flag_d, z_flag_q;
    logic             a_grt_b_d, a_grt_b_q;
    logic             b_grt_a_d, b_grt_a_q;

    alu_core u_core (
        .a_i    (d_in_1),
        .b_i    (d_in_2),
        .op_i   (alu_op_e'(alu_op)),
        .r_o    (d_out_d),
        .zero_o (z_flag_d),
        .gt_o   (a_grt_b_d),
        .lt_o   (b_grt_a_d)
    );

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out_q   <= '0;
            z_flag_q  <= 1'b0;
            a_grt_b_q <= 1'b0;
            b_grt_a_q <= 1'b0;
        end else begin
            d_out_q   <= d_out_d;
            z_flag_q  <= z_flag_d;
            a_grt_b_q <= a_grt_b_d;
            b_grt_a_q <= b_grt_a_d;
        end
    end

    assign d_out   = d_out_q;
    assign z_flag  = z_flag_q;
    assign a_grt_b = a_grt_b_q;
    assign b_grt_a = b_grt_a_q;

endmodule

// File: tb/tb_alu_main.sv
// Self-checking bench for alu_main: directed vectors plus a per-cycle model comparison.
module tb_alu_main;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [31:0] d_out;
    logic        z_flag;
    logic        a_grt_b;
    logic        b_grt_a;

    int checks = 0;
    int errors = 0;

    alu_main dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_in_1  (a),
        .d_in_2  (b),
        .alu_op  (op),
        .d_out   (d_out),
        .z_flag  (z_flag),
        .a_grt_b (a_grt_b),
        .b_grt_a (b_grt_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Result from the arithmetic meaning of each opcode.
    function automatic logic [31:0] model_r(input logic [15:0] x, input logic [15:0] y,
                                             input logic [2:0] o);
        longint s;
        case (o)
            3'd0: begin
                s = (longint'(x) + longint'(y)) % 65536;
                if (s >= 32768) s = s + 64'hFFFF_0000;
                return 32'(s);
            end
            3'd1: return 32'(longint'(x) * longint'(y));
            3'd2: return {16'd0, x & y};
            3'd3: return {16'd0, x | y};
            3'd4: return 32'(longint'(x) / 2);
            3'd5: return (x > y) ? 32'd1 : 32'd0;
            3'd6: return (x < y) ? 32'd1 : 32'd0;
            default: begin
                s = longint'(x) * (longint'(1) << y[3:0]);
                return 32'(s);
            end
        endcase
    endfunction

    // Per-cycle compare against the model using the inputs present at each rising edge.
    always @(posedge clk) begin
        logic [31:0] er;
        logic        ez, eg, el;
        if (rst_n) begin
            er = model_r(a, b, op);
            ez = (er == 32'd0);
            eg = (a > b);
            el = (b > a);
        end else begin
            er = 32'd0; ez = 1'b0; eg = 1'b0; el = 1'b0;
        end
        #1;
        check("cyc_d_out",   d_out,          er);
        check("cyc_z_flag",  32'(z_flag),    32'(ez));
        check("cyc_a_grt_b", 32'(a_grt_b),   32'(eg));
        check("cyc_b_grt_a", 32'(b_grt_a),   32'(el));
    end

    task automatic vec(input string name, input logic [15:0] x, input logic [15:0] y,
                       input logic [2:0] o, input logic [31:0] ed, input logic ez,
                       input logic eg, input logic el);
        @(negedge clk);
        a = x; b = y; op = o;
        @(posedge clk);
        #2;
        check({name, "_d"},  d_out,        ed);
        check({name, "_z"},  32'(z_flag),  32'(ez));
        check({name, "_ag"}, 32'(a_grt_b), 32'(eg));
        check({name, "_bg"}, 32'(b_grt_a), 32'(el));
    endtask

    // Literal values that pin the model itself.
    initial begin
        check("model_mul_max", model_r(16'hFFFF, 16'hFFFF, 3'd1), 32'hFFFE_0001);
        check("model_sll15",   model_r(16'hFFFF, 16'd15,   3'd7), 32'h7FFF_8000);
        check("model_add_neg", model_r(16'd0,    16'hFFFF, 3'd0), 32'hFFFF_FFFF);
    end

    initial begin
        rst_n = 1'b0;
        a = 16'($urandom); b = 16'($urandom); op = 3'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom); op = 3'($urandom);
            check("rst_d_out", d_out, 32'd0);
            check("rst_flags", {29'd0, z_flag, a_grt_b, b_grt_a}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a = 16'd1; b = 16'd10; op = 3'b000;
        #2;
        check("hold_after_release", d_out, 32'd0);

        vec("first_add",  16'd1,     16'd10,    3'b000, 32'd11,          1'b0, 1'b0, 1'b1);
        vec("add_sub",    16'd30,    16'hFFEC,  3'b000, 32'd10,          1'b0, 1'b0, 1'b1);
        vec("add_neg",    16'd0,     16'hFFFF,  3'b000, 32'hFFFF_FFFF,   1'b0, 1'b0, 1'b1);
        vec("add_wrap0",  16'd1,     16'hFFFF,  3'b000, 32'd0,           1'b1, 1'b0, 1'b1);
        vec("mul_small",  16'd40,    16'd50,    3'b001, 32'd2000,        1'b0, 1'b0, 1'b1);
        vec("mul_big",    16'd45000, 16'd60000, 3'b001, 32'hA0EE_BB00,   1'b0, 1'b0, 1'b1);
        vec("mul_max",    16'hFFFF,  16'hFFFF,  3'b001, 32'hFFFE_0001,   1'b0, 1'b0, 1'b0);
        vec("and_mix",    16'd453,   16'd567,   3'b010, 32'h0000_0005,   1'b0, 1'b0, 1'b1);
        vec("and_ones",   16'hFFFF,  16'hFFFF,  3'b010, 32'h0000_FFFF,   1'b0, 1'b0, 1'b0);
        vec("or_mix",     16'd453,   16'd567,   3'b011, 32'h0000_03F7,   1'b0, 1'b0, 1'b1);
        vec("or_zero",    16'd0,     16'd0,     3'b011, 32'd0,           1'b1, 1'b0, 1'b0);
        vec("halve",      16'd39,    16'd0,     3'b100, 32'd19,          1'b0, 1'b1, 1'b0);
        vec("gt_true",    16'd40,    16'd20,    3'b101, 32'd1,           1'b0, 1'b1, 1'b0);
        vec("gt_equal",   16'd40,    16'd40,    3'b101, 32'd0,           1'b1, 1'b0, 1'b0);
        vec("lt_true",    16'd20,    16'd40,    3'b110, 32'd1,           1'b0, 1'b0, 1'b1);
        vec("sll_2",      16'd9000,  16'd2,     3'b111, 32'd36000,       1'b0, 1'b1, 1'b0);
        vec("sll_15",     16'hFFFF,  16'd15,    3'b111, 32'h7FFF_8000,   1'b0, 1'b1, 1'b0);
        vec("sll_hi_ign", 16'd3,     16'hFFF1,  3'b111, 32'd6,           1'b0, 1'b0, 1'b1);

        // Inputs changing between edges must not disturb the registered result.
        a = 16'd7; b = 16'd7; op = 3'b001;
        #1;
        check("midcycle_hold", d_out, 32'h0000_0006);

        // Back-to-back stream; the per-cycle compare verifies one-clock latency.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            a = 16'($urandom); b = (i % 5 == 0) ? a : 16'($urandom); op = 3'(i);
        end

        // Asynchronous reset in the middle of the stream.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_d_out", d_out, 32'd0);
        check("async_rst_flags", {29'd0, z_flag, a_grt_b, b_grt_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        vec("post_rst", 16'd100, 16'd3, 3'b001, 32'd300, 1'b0, 1'b1, 1'b0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_main.md
Name: alu_main

Overview:
- Registered 16-bit integer ALU for the 16-bit RISC core datapath.
- Takes two 16-bit operands and a 3-bit opcode; produces a 32-bit result, a zero flag and two unsigned magnitude-compare flags.
- All outputs are registered with one-cycle latency; there is no handshake and a new operation is accepted every cycle.

Parameters:
- DATA_W, 16, operand width. Result width is 2*DATA_W. All values below assume the default.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- d_in_1  input  16  operand A, unsigned except for ADD
- d_in_2  input  16  operand B
- alu_op  input  3  operation select
- d_out  output  32  registered result
- z_flag  output  1  registered; 1 when the result being loaded into d_out is all zeros
- a_grt_b  output  1  registered; A > B, unsigned
- b_grt_a  output  1  registered; B > A, unsigned

Behaviour:
- Reset (rst_n low, asynchronous): d_out=0, z_flag=0, a_grt_b=0, b_grt_a=0. Outputs hold these values until the first rising clk after rst_n deasserts.
- Each rising clk with rst_n high registers the combinational result of the current inputs. Latency is 1 cycle and throughput is 1 operation per cycle. There is no stall or enable.
- Opcode map (result R, 32-bit):
  - 000 ADD: 16-bit two's-complement sum, wrapped mod 2^16, sign-extended to 32 bits. Carry and overflow are discarded.
  - 001 MUL: unsigned 16x16 -> full 32-bit product; never truncated.
  - 010 AND: zero-extended A & B.
  - 011 OR: zero-extended A | B.
  - 100 HALVE: zero-extended A >> 1, logical. Operand B is ignored.
  - 101 GT: R = 1 if A > B (unsigned), else 0.
  - 110 LT: R = 1 if A < B (unsigned), else 0.
  - 111 SLL: ({16'b0, A} << B[3:0]), 32 bits wide, so no bits are lost. B[15:4] is ignored.
- z_flag: registered (R == 0) for every opcode, including compare results.
- a_grt_b and b_grt_a: unsigned compares of A and B, updated every cycle regardless of opcode.
  - Both are 0 when A == B.
  - They are never both 1.
- Boundary conditions:
  - An ADD result of 0x8000..0xFFFF yields an upper half of 0xFFFF.
  - 0xFFFF*0xFFFF = 0xFFFE0001.
  - A shift by 15 of 0xFFFF = 0x7FFF8000.
  - An input change between clock edges has no effect until the next edge.
  - Reset asserted mid-stream clears all outputs immediately; no partial result survives.
- No X propagation: all opcodes are defined. A default branch selects R = 0.

Decomposition:
- Package alu_pkg:
  - DATA_W constant.
  - typedef alu_op_e, a 3-bit enum: OP_ADD, OP_MUL, OP_AND, OP_OR, OP_HALVE, OP_GT, OP_LT, OP_SLL.
- One sub-module, alu_core: purely combinational.
  - Inputs: A, B, op.
  - Outputs: R, zero, gt, lt.
- alu_main wraps alu_core with the output register stage and reset.

Test Plan:
- Reset: hold rst_n low with random inputs -> all outputs 0. Deassert; A=1, B=10, op=000 -> after 1 clk d_out=11, z_flag=0, a_grt_b=0, b_grt_a=1.
- ADD as subtract and wrap:
  - A=30, B=0xFFEC (-20), op=000 -> d_out=10.
  - A=0, B=0xFFFF -> d_out=0xFFFFFFFF.
  - A=1, B=0xFFFF -> d_out=0, z_flag=1.
- MUL:
  - A=40, B=50, op=001 -> d_out=2000.
  - A=45000, B=60000 -> d_out=0xA0EEBB00.
  - A=B=0xFFFF -> d_out=0xFFFE0001.
- Logic:
  - AND: A=453, B=567, op=010 -> d_out=0x0005.
  - AND: A=B=0xFFFF -> d_out=0x0000FFFF.
  - OR: A=453, B=567, op=011 -> d_out=0x03F7.
  - OR: A=B=0, op=011 -> d_out=0, z_flag=1.
- HALVE / compare:
  - A=39, B=0, op=100 -> d_out=19.
  - A=40, B=20, op=101 -> d_out=1, a_grt_b=1.
  - A=B=40, op=101 -> d_out=0, z_flag=1, both compare flags 0.
  - A=20, B=40, op=110 -> d_out=1, b_grt_a=1.
- SLL and pipelining:
  - A=9000, B=2, op=111 -> d_out=36000.
  - A=0xFFFF, B=15 -> d_out=0x7FFF8000.
  - Change operands every cycle -> each result appears exactly 1 clk later.
  - Assert rst_n mid-stream -> outputs 0 immediately, without waiting for a clk edge.
